// File: rtl/tx_pkg.sv
// Shared definitions for the 802.11a PPDU framer: rate codes, N_DBPS lookup,
// SIGNAL field layout and FSM states.
package tx_pkg;

  localparam logic [3:0] RATE_6  = 4'b1101;
  localparam logic [3:0] RATE_9  = 4'b1111;
  localparam logic [3:0] RATE_12 = 4'b0101;
  localparam logic [3:0] RATE_18 = 4'b0111;
  localparam logic [3:0] RATE_24 = 4'b1001;
  localparam logic [3:0] RATE_36 = 4'b1011;
  localparam logic [3:0] RATE_48 = 4'b0001;
  localparam logic [3:0] RATE_54 = 4'b0011;

  localparam int unsigned SIG_RATE_W       = 4;
  localparam int unsigned SIG_LEN_W        = 12;
  localparam int unsigned SIG_TAIL_W       = 6;
  localparam int unsigned SIG_BITS         = 24;
  localparam int unsigned SERVICE_BITS_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIGNAL,
    ST_SERVICE,
    ST_PSDU,
    ST_TAIL,
    ST_PAD,
    ST_DONE
  } state_t;

  // Zero marks an unlisted rate code.
  function automatic logic [7:0] ndbps_lookup(input logic [SIG_RATE_W-1:0] rate);
    case (rate)
      RATE_6:  ndbps_lookup = 8'd24;
      RATE_9:  ndbps_lookup = 8'd36;
      RATE_12: ndbps_lookup = 8'd48;
      RATE_18: ndbps_lookup = 8'd72;
      RATE_24: ndbps_lookup = 8'd96;
      RATE_36: ndbps_lookup = 8'd144;
      RATE_48: ndbps_lookup = 8'd192;
      RATE_54: ndbps_lookup = 8'd216;
      default: ndbps_lookup = 8'd0;
    endcase
  endfunction

  // Bit 0 is transmitted first: R1..R4, reserved, LENGTH LSB first, parity, tail.
  function automatic logic [SIG_BITS-1:0] signal_field(input logic [SIG_RATE_W-1:0] rate,
                                                       input logic [SIG_LEN_W-1:0]  len);
    logic [16:0] head;
    head = {len, 1'b0, rate[0], rate[1], rate[2], rate[3]};
    signal_field = {{SIG_TAIL_W{1'b0}}, ^head, head};
  endfunction

endpackage

// File: rtl/tx_byte_serializer.sv
// PSDU byte intake: one holding register feeding an 8-bit shift register,
// serialised LSB or MSB first, with a valid/ready byte handshake.
module tx_byte_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_allow,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte,
  input  logic       i_take,
  output logic       o_ready,
  output logic       o_avail,
  output logic       o_bit
);

  logic [7:0] r_hold;
  logic [7:0] r_shift;
  logic       r_hold_full;
  logic [3:0] r_left;
  logic [7:0] w_src;
  logic       w_from_hold;

  // An empty shift register lets the first bit come straight from the holding register.
  assign w_from_hold = (r_left == '0);
  assign w_src       = w_from_hold ? r_hold : r_shift;
  assign o_bit       = MSB_FIRST ? w_src[7] : w_src[0];
  assign o_avail     = !w_from_hold || r_hold_full;
  assign o_ready     = i_allow && !r_hold_full;

  function automatic logic [7:0] advance(input logic [7:0] v);
    return MSB_FIRST ? {v[6:0], 1'b0} : {1'b0, v[7:1]};
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hold      <= '0;
      r_shift     <= '0;
      r_hold_full <= 1'b0;
      r_left      <= '0;
    end else begin
      if (i_take && o_avail) begin
        r_shift <= advance(w_src);
        r_left  <= w_from_hold ? 4'd7 : r_left - 4'd1;
        if (w_from_hold) r_hold_full <= 1'b0;
      end
      if (i_byte_valid && o_ready) begin
        r_hold      <= i_byte;
        r_hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_ppdu_framer.sv
// 802.11a TX serial front end: emits SIGNAL, SERVICE, PSDU, tail and pad bits,
// one bit per bit-enable strobe, with registered outputs.
module tx_ppdu_framer
  import tx_pkg::*;
#(
  parameter int unsigned LEN_W        = 12,
  parameter bit          MSB_FIRST    = 1'b0,
  parameter int unsigned SERVICE_BITS = SERVICE_BITS_DEF
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iBitEn,
  input  logic             iStart,
  input  logic [3:0]       iRate,
  input  logic [LEN_W-1:0] iLength,
  input  logic [7:0]       iByte,
  input  logic             iByteValid,
  output logic             oByteReady,
  output logic             oData,
  output logic             oValid,
  output logic             oSigField,
  output logic             oTail,
  output logic             oBusy,
  output logic             oDone,
  output logic             oErr,
  output logic             oUnderrun
);

  localparam int unsigned CNT_W = (LEN_W + 3 > 16) ? LEN_W + 3 : 16;

  state_t              r_state, w_state_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [7:0]          r_sym, w_sym_nx, w_sym_inc;
  logic [7:0]          r_ndbps, w_req_ndbps;
  logic [LEN_W-1:0]    r_len, r_req_cnt;
  logic [SIG_BITS-1:0] r_sigvec;
  logic                r_data, r_valid, r_sigf, r_tail, r_done, r_err, r_underrun;
  logic                w_data_nx, w_valid_nx, w_sigf_nx, w_tail_nx, w_done_nx, w_err_nx, w_under_nx;
  logic                w_req_ok, w_accept, w_take, w_allow, w_xfer, w_bit_avail, w_ser_bit;
  logic [CNT_W-1:0]    w_psdu_last;

  assign w_req_ndbps = ndbps_lookup(iRate);
  assign w_req_ok    = (w_req_ndbps != '0) && (iLength != '0);
  assign w_sym_inc   = (r_sym == r_ndbps - 8'd1) ? '0 : r_sym + 8'd1;
  assign w_psdu_last = CNT_W'({r_len, 3'b000}) - CNT_W'(1);
  assign w_allow     = ((r_state == ST_SERVICE) || (r_state == ST_PSDU)) && (r_req_cnt < r_len);
  assign w_xfer      = iByteValid && oByteReady;

  tx_byte_serializer #(
    .MSB_FIRST(MSB_FIRST)
  ) u_ser (
    .i_clk       (iClk),
    .i_rst_n     (iRst),
    .i_allow     (w_allow),
    .i_byte_valid(iByteValid),
    .i_byte      (iByte),
    .i_take      (w_take),
    .o_ready     (oByteReady),
    .o_avail     (w_bit_avail),
    .o_bit       (w_ser_bit)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sym_nx   = r_sym;
    w_data_nx  = 1'b0;
    w_valid_nx = 1'b0;
    w_sigf_nx  = 1'b0;
    w_tail_nx  = 1'b0;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    w_under_nx = r_underrun;
    w_take     = 1'b0;
    w_accept   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (iStart) begin
          if (w_req_ok) begin
            w_accept   = 1'b1;
            w_under_nx = 1'b0;
            w_cnt_nx   = '0;
            w_sym_nx   = '0;
            w_state_nx = ST_SIGNAL;
          end else begin
            w_err_nx = 1'b1;
          end
        end
      end
      ST_SIGNAL: begin
        if (iBitEn) begin
          w_valid_nx = 1'b1;
          w_sigf_nx  = 1'b1;
          w_data_nx  = r_sigvec[r_cnt[4:0]];
          if (r_cnt == CNT_W'(SIG_BITS - 1)) begin
            w_cnt_nx   = '0;
            w_state_nx = ST_SERVICE;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      ST_SERVICE: begin
        if (iBitEn) begin
          w_valid_nx = 1'b1;
          w_sym_nx   = w_sym_inc;
          if (r_cnt == CNT_W'(SERVICE_BITS - 1)) begin
            w_cnt_nx   = '0;
            w_state_nx = ST_PSDU;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      ST_PSDU: begin
        // Starved strobes emit nothing and freeze both counters.
        if (iBitEn) begin
          if (w_bit_avail) begin
            w_valid_nx = 1'b1;
            w_data_nx  = w_ser_bit;
            w_take     = 1'b1;
            w_sym_nx   = w_sym_inc;
            if (r_cnt == w_psdu_last) begin
              w_cnt_nx   = '0;
              w_state_nx = ST_TAIL;
            end else begin
              w_cnt_nx = r_cnt + 1'b1;
            end
          end else begin
            w_under_nx = 1'b1;
          end
        end
      end
      ST_TAIL: begin
        if (iBitEn) begin
          w_valid_nx = 1'b1;
          w_tail_nx  = 1'b1;
          w_sym_nx   = w_sym_inc;
          if (r_cnt == CNT_W'(SIG_TAIL_W - 1)) begin
            w_cnt_nx   = '0;
            w_state_nx = (w_sym_inc == '0) ? ST_DONE : ST_PAD;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      ST_PAD: begin
        if (iBitEn) begin
          w_valid_nx = 1'b1;
          w_sym_nx   = w_sym_inc;
          if (w_sym_inc == '0) w_state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done_nx  = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_sym      <= '0;
      r_ndbps    <= '0;
      r_len      <= '0;
      r_req_cnt  <= '0;
      r_sigvec   <= '0;
      r_data     <= 1'b0;
      r_valid    <= 1'b0;
      r_sigf     <= 1'b0;
      r_tail     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_sym      <= w_sym_nx;
      r_data     <= w_data_nx;
      r_valid    <= w_valid_nx;
      r_sigf     <= w_sigf_nx;
      r_tail     <= w_tail_nx;
      r_done     <= w_done_nx;
      r_err      <= w_err_nx;
      r_underrun <= w_under_nx;
      if (w_accept) begin
        r_len     <= iLength;
        r_ndbps   <= w_req_ndbps;
        r_sigvec  <= signal_field(iRate, SIG_LEN_W'(iLength));
        r_req_cnt <= '0;
      end else if (w_xfer) begin
        r_req_cnt <= r_req_cnt + 1'b1;
      end
    end
  end

  assign oData     = r_data;
  assign oValid    = r_valid;
  assign oSigField = r_sigf;
  assign oTail     = r_tail;
  assign oBusy     = (r_state != ST_IDLE);
  assign oDone     = r_done;
  assign oErr      = r_err;
  assign oUnderrun = r_underrun;

endmodule

// File: tb/tb_tx_ppdu_framer.sv
// Bench for tx_ppdu_framer: two instances (LSB-first and MSB-first) share one
// randomized stimulus and are checked against a bit-list model of the PPDU.
module tb_tx_ppdu_framer;

  localparam int unsigned LEN_W       = 12;
  localparam int unsigned SVC         = 16;
  localparam int unsigned FRAME_LIMIT = 20000;

  logic             iClk = 1'b0;
  logic             iRst, iBitEn, iStart, iByteValid;
  logic [3:0]       iRate;
  logic [LEN_W-1:0] iLength;
  logic [7:0]       iByte;
  logic oByteReady, oData, oValid, oSigField, oTail, oBusy, oDone, oErr, oUnderrun;
  logic m_oByteReady, m_oData, m_oValid, m_oSigField, m_oTail, m_oBusy, m_oDone, m_oErr, m_oUnderrun;

  always #5 iClk = ~iClk;

  tx_ppdu_framer #(.LEN_W(LEN_W), .MSB_FIRST(1'b0), .SERVICE_BITS(SVC)) u_lsb (
    .iClk(iClk), .iRst(iRst), .iBitEn(iBitEn), .iStart(iStart), .iRate(iRate),
    .iLength(iLength), .iByte(iByte), .iByteValid(iByteValid), .oByteReady(oByteReady),
    .oData(oData), .oValid(oValid), .oSigField(oSigField), .oTail(oTail), .oBusy(oBusy),
    .oDone(oDone), .oErr(oErr), .oUnderrun(oUnderrun)
  );

  tx_ppdu_framer #(.LEN_W(LEN_W), .MSB_FIRST(1'b1), .SERVICE_BITS(SVC)) u_msb (
    .iClk(iClk), .iRst(iRst), .iBitEn(iBitEn), .iStart(iStart), .iRate(iRate),
    .iLength(iLength), .iByte(iByte), .iByteValid(iByteValid), .oByteReady(m_oByteReady),
    .oData(m_oData), .oValid(m_oValid), .oSigField(m_oSigField), .oTail(m_oTail), .oBusy(m_oBusy),
    .oDone(m_oDone), .oErr(m_oErr), .oUnderrun(m_oUnderrun)
  );

  typedef struct packed {
    logic d;
    logic s;
    logic t;
  } exp_t;

  exp_t        exp_q[$];
  logic        exp_m[$];
  logic [7:0]  cur_bytes[$];
  int unsigned n_vec = 0, n_fail = 0;
  int unsigned done_cnt = 0, f_valid = 0, f_tail = 0, f_sig = 0, hs_cnt = 0, byte_idx = 0;
  logic        last_en = 1'b0;
  logic        xfer;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned ndbps_of(input logic [3:0] r);
    case (r)
      4'b1101: return 24;
      4'b1111: return 36;
      4'b0101: return 48;
      4'b0111: return 72;
      4'b1001: return 96;
      4'b1011: return 144;
      4'b0001: return 192;
      4'b0011: return 216;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned data_bits(input int unsigned ndb, input int unsigned len);
    int unsigned raw;
    raw = SVC + 8 * len + 6;
    return ndb * ((raw + ndb - 1) / ndb);
  endfunction

  function automatic logic [0:23] sig_bits(input logic [3:0] r, input int unsigned len);
    logic [0:23] s;
    logic        p;
    s    = '0;
    s[0] = r[3];
    s[1] = r[2];
    s[2] = r[1];
    s[3] = r[0];
    for (int unsigned i = 0; i < 12; i++) s[5+i] = 1'((len >> i) & 1);
    p = 1'b0;
    for (int unsigned i = 0; i < 17; i++) p = p ^ s[i];
    s[17] = p;
    return s;
  endfunction

  function automatic logic [0:7] byte_bits(input logic [7:0] b, input bit msb);
    logic [0:7] o;
    for (int unsigned i = 0; i < 8; i++) o[i] = msb ? b[7-i] : b[i];
    return o;
  endfunction

  task automatic build_model(input logic [3:0] rate, input int unsigned len);
    logic [0:23] s;
    logic [0:7]  bl, bm;
    int unsigned total;
    exp_q.delete();
    exp_m.delete();
    s = sig_bits(rate, len);
    for (int unsigned i = 0; i < 24; i++) begin
      exp_q.push_back('{d: s[i], s: 1'b1, t: 1'b0});
      exp_m.push_back(s[i]);
    end
    for (int unsigned i = 0; i < SVC; i++) begin
      exp_q.push_back('{d: 1'b0, s: 1'b0, t: 1'b0});
      exp_m.push_back(1'b0);
    end
    for (int unsigned k = 0; k < len; k++) begin
      bl = byte_bits(cur_bytes[k], 1'b0);
      bm = byte_bits(cur_bytes[k], 1'b1);
      for (int unsigned i = 0; i < 8; i++) begin
        exp_q.push_back('{d: bl[i], s: 1'b0, t: 1'b0});
        exp_m.push_back(bm[i]);
      end
    end
    for (int unsigned i = 0; i < 6; i++) begin
      exp_q.push_back('{d: 1'b0, s: 1'b0, t: 1'b1});
      exp_m.push_back(1'b0);
    end
    total = data_bits(ndbps_of(rate), len);
    for (int unsigned i = SVC + 8 * len + 6; i < total; i++) begin
      exp_q.push_back('{d: 1'b0, s: 1'b0, t: 1'b0});
      exp_m.push_back(1'b0);
    end
  endtask

  // ---------------- per-cycle compare + byte source bookkeeping ----------------
  task automatic tick();
    exp_t e;
    logic em;
    @(negedge iClk);
    if (oValid) begin
      f_valid++;
      if (oSigField) f_sig++;
      if (oTail) f_tail++;
      chk("valid_needs_biten", 32'(last_en), 32'd1);
      if (exp_q.size() == 0) chk("extra_bit", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("data", 32'(oData), 32'(e.d));
        chk("sigfield", 32'(oSigField), 32'(e.s));
        chk("tail", 32'(oTail), 32'(e.t));
      end
    end
    if (m_oValid) begin
      if (exp_m.size() == 0) chk("msb_extra_bit", 32'd1, 32'd0);
      else begin
        em = exp_m.pop_front();
        chk("msb_data", 32'(m_oData), 32'(em));
      end
    end
    if (oDone) begin
      done_cnt++;
      chk("busy_at_done", 32'(oBusy), 32'd0);
    end
    xfer    = iByteValid && oByteReady;
    last_en = iBitEn;
    @(posedge iClk);
    #1;
    if (xfer) begin
      byte_idx++;
      hs_cnt++;
    end
  endtask

  task automatic start_frame(input logic [3:0] rate, input int unsigned len, input bit fixed_a5);
    f_valid = 0; f_tail = 0; f_sig = 0; hs_cnt = 0; byte_idx = 0;
    cur_bytes.delete();
    for (int unsigned i = 0; i < len; i++) cur_bytes.push_back(fixed_a5 ? 8'hA5 : 8'($urandom));
    build_model(rate, len);
    iRate = rate; iLength = LEN_W'(len); iByte = cur_bytes[0];
    iStart = 1'b1; iBitEn = 1'b0; iByteValid = 1'b0;
    tick();
    iStart = 1'b0;
    chk("busy_after_start", 32'(oBusy), 32'd1);
    chk("underrun_cleared", 32'(oUnderrun), 32'd0);
  endtask

  // vmode: 0 bytes always valid, 1 random valid, 2 valid dropped 20 cycles mid-PSDU
  task automatic run_frame(input logic [3:0] rate, input int unsigned len, input int unsigned en_div,
                           input int unsigned vmode, input bit restart, input bit fixed_a5);
    int unsigned d0, guard, stall;
    d0 = done_cnt;
    start_frame(rate, len, fixed_a5);
    guard = 0;
    stall = 0;
    while (done_cnt == d0 && guard < FRAME_LIMIT) begin
      iBitEn = (en_div <= 1) ? 1'b1 : ($urandom_range(en_div - 1) == 0);
      case (vmode)
        0: iByteValid = 1'b1;
        1: iByteValid = ($urandom_range(3) != 0);
        default: begin
          if (stall == 0 && byte_idx == len / 2) stall = 1;
          if (stall > 0 && stall <= 20) begin
            iByteValid = 1'b0;
            stall++;
          end else iByteValid = 1'b1;
        end
      endcase
      iByte  = (byte_idx < len) ? cur_bytes[byte_idx] : 8'($urandom);
      iStart = restart && (guard == 150);
      if (iStart) begin
        iRate   = 4'b1101;
        iLength = LEN_W'(7);
      end
      tick();
      guard++;
    end
    iStart = 1'b0; iBitEn = 1'b0; iByteValid = 1'b0;
    chk("frame_timeout", 32'(guard < FRAME_LIMIT), 32'd1);
    chk("done_once", done_cnt - d0, 32'd1);
    chk("valid_bits", f_valid, 24 + data_bits(ndbps_of(rate), len));
    chk("sig_bits", f_sig, 32'd24);
    chk("tail_bits", f_tail, 32'd6);
    chk("handshakes", hs_cnt, len);
    chk("model_drained", exp_q.size() + exp_m.size(), 32'd0);
    if (vmode != 1) chk("underrun_flag", 32'(oUnderrun), (vmode == 2) ? 32'd1 : 32'd0);
  endtask

  task automatic req_err(input logic [3:0] rate, input int unsigned len);
    exp_q.delete();
    exp_m.delete();
    iRate = rate; iLength = LEN_W'(len); iStart = 1'b1; iBitEn = 1'b1; iByteValid = 1'b1;
    tick();
    iStart = 1'b0;
    chk("err_pulse", 32'(oErr), 32'd1);
    chk("err_busy", 32'(oBusy), 32'd0);
    tick();
    chk("err_one_cycle", 32'(oErr), 32'd0);
    repeat (10) tick();
    chk("err_stays_idle", 32'({oBusy, oValid}), 32'd0);
    iBitEn = 1'b0; iByteValid = 1'b0;
  endtask

  logic [3:0]  rates[8] = '{4'b1101, 4'b1111, 4'b0101, 4'b0111, 4'b1001, 4'b1011, 4'b0001, 4'b0011};
  int unsigned ens[3]   = '{1, 2, 4};

  initial begin
    logic [0:23] lit_sig;
    logic [0:7]  lit8;
    int unsigned d0, guard;

    iRst = 1'b0; iBitEn = 1'b0; iStart = 1'b0; iRate = '0; iLength = '0;
    iByte = '0; iByteValid = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 32'({oData, oValid, oSigField, oTail, oBusy, oDone, oErr, oUnderrun, oByteReady}), 32'd0);
    iRst = 1'b1;
    tick();

    // Hand-computed pins for the model itself.
    lit_sig = 24'b1011_0001_0011_0000_0000_0000;
    chk("model_sig_1011_100", 32'(sig_bits(4'b1011, 100)), 32'(lit_sig));
    chk("model_total_1011_100", data_bits(ndbps_of(4'b1011), 100), 32'd864);
    chk("model_total_1101_1", data_bits(ndbps_of(4'b1101), 1), 32'd48);
    chk("model_total_0011_27", data_bits(ndbps_of(4'b0011), 27), 32'd432);
    lit8 = 8'b10100101;
    chk("model_a5_lsb", 32'(byte_bits(8'hA5, 1'b0)), 32'(lit8));
    lit8 = 8'b00011100;
    chk("model_1c_msb", 32'(byte_bits(8'h1C, 1'b1)), 32'(lit8));
    lit8 = 8'b00111000;
    chk("model_1c_lsb", 32'(byte_bits(8'h1C, 1'b0)), 32'(lit8));

    run_frame(4'b1011, 100, 1, 0, 1'b0, 1'b0);
    run_frame(4'b1101, 1, 1, 0, 1'b0, 1'b1);
    req_err(4'b0000, 5);
    req_err(4'b1101, 0);
    req_err(4'b1100, 3);
    run_frame(4'b0101, 12, 1, 2, 1'b0, 1'b0);
    run_frame(4'b0111, 10, 4, 0, 1'b1, 1'b0);

    // Reset in the middle of the PSDU.
    d0 = done_cnt;
    start_frame(4'b1101, 20, 1'b0);
    guard = 0;
    while (byte_idx < 4 && guard < 500) begin
      iBitEn = 1'b1; iByteValid = 1'b1; iByte = cur_bytes[byte_idx];
      tick();
      guard++;
    end
    chk("reset_reach_psdu", 32'(guard < 500), 32'd1);
    iRst = 1'b0;
    tick();
    chk("reset_midframe_outputs",
        32'({oData, oValid, oSigField, oTail, oBusy, oDone, oErr, oUnderrun, oByteReady}), 32'd0);
    iRst = 1'b1; iByteValid = 1'b0;
    exp_q.delete();
    exp_m.delete();
    repeat (40) begin
      iBitEn = 1'b1;
      tick();
    end
    chk("no_done_after_reset", done_cnt - d0, 32'd0);
    iBitEn = 1'b0;

    run_frame(4'b0011, 27, 1, 0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++)
      run_frame(rates[$urandom_range(7)], $urandom_range(40, 1), ens[$urandom_range(2)], 1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_ppdu_framer.md
Name: tx_ppdu_framer

Overview:
Parametrised successor to the serial front end of the 802.11a TX controller. Accepts a frame request (RATE, LENGTH) and a byte-wide PSDU stream with a valid/ready handshake. Emits the PPDU bit stream serially, one bit per bit-enable strobe, in this order: SIGNAL field, SERVICE, PSDU, tail, pad. Sits ahead of the scrambler, encoder and interleaver. Generalises the fixed-rate, single-bit-input front end with byte input, selectable bit order, rate validation and automatic padding.

Parameters:
LEN_W, 12, width of LENGTH field; maximum PSDU length is 2^LEN_W-1 octets
MSB_FIRST, 0, 0 = PSDU byte bits serialised LSB first (802.11a); 1 = MSB first
SERVICE_BITS, 16, number of zero SERVICE bits prepended to the DATA field

Ports:
iClk  in  1  system clock
iRst  in  1  synchronous reset, active-low
iBitEn  in  1  bit-rate strobe; output advances one bit per cycle with iBitEn=1
iStart  in  1  frame request, sampled only in IDLE
iRate  in  4  RATE code R1..R4 (iRate[3]=R1)
iLength  in  LEN_W  PSDU length in octets
iByte  in  8  PSDU byte
iByteValid  in  1  iByte valid
oByteReady  out  1  framer accepts iByte this cycle
oData  out  1  serial output bit
oValid  out  1  oData valid (one cycle per emitted bit)
oSigField  out  1  current bit belongs to SIGNAL field
oTail  out  1  current bit is a DATA tail bit (downstream scrambler forces it to 0)
oBusy  out  1  frame in progress
oDone  out  1  one-cycle pulse after last pad bit
oErr  out  1  one-cycle pulse on rejected request
oUnderrun  out  1  sticky: PSDU byte not available when needed; cleared by next accepted iStart

Behaviour:
- Reset (iRst=0 at posedge): state IDLE; all outputs 0; counters and buffers cleared. Reset mid-frame discards the frame and emits no oDone.
- Rate table (code->N_DBPS): 1101->24, 1111->36, 0101->48, 0111->72, 1001->96, 1011->144, 0001->192, 0011->216.
- Request check in IDLE with iStart=1: an unlisted rate or iLength=0 gives oErr=1 on the next cycle and the framer stays IDLE. Otherwise it latches rate, length and N_DBPS, sets oBusy=1 on the next cycle and clears oUnderrun.
- iStart outside IDLE is ignored.
- States: IDLE -> SIGNAL(24) -> SERVICE(SERVICE_BITS) -> PSDU(8*LEN) -> TAIL(6) -> PAD(0..N_DBPS-1) -> DONE -> IDLE.
  - The number in brackets is the bit count emitted in that state.
  - PAD is skipped when the symbol counter is 0 after TAIL.
- SIGNAL bit order:
  - RATE R1..R4
  - reserved 0
  - LENGTH LSB first (12 bits, zero-extended or truncated to 12)
  - even parity over bits 0..16
  - six zeros
  - oSigField=1 for all 24 bits.
- Symbol counter:
  - Modulo-N_DBPS counter runs over the DATA field only (SERVICE onward), so no divider is needed.
  - PAD ends when the counter wraps to 0.
  - Total DATA bits = N_DBPS*ceil((SERVICE_BITS+8*LEN+6)/N_DBPS).
- Output timing: oData, oValid and the flags are registered. A bit appears the cycle after the iBitEn that produced it. The first SIGNAL bit follows the first iBitEn at or after oBusy rises.
- Byte path:
  - One holding register plus one 8-bit shift register.
  - oByteReady=1 when the holding register is empty, state is SERVICE or PSDU, and requested bytes < LEN.
  - A transfer occurs when iByteValid & oByteReady.
  - Extra bytes beyond LEN are never requested.
- Underrun: in PSDU, on iBitEn with the shift register empty and the holding register empty, no bit is emitted (oValid=0) and the counters hold. oUnderrun=1 until the next accepted iStart. Emission resumes when a byte arrives.
- oDone pulses in the cycle after the final pad (or tail) bit is registered; oBusy falls in the same cycle. A new iStart is accepted from that cycle onward.
- Simultaneous iStart and iRst=0: reset wins.

Decomposition:
- Shared package tx_pkg:
  - rate code constants
  - N_DBPS lookup function
  - state enum/localparams
  - SIGNAL field widths (RATE 4, LENGTH 12, tail 6)
  - SERVICE_BITS default
- Natural sub-module: tx_byte_serializer, covering the holding register, shift register, MSB_FIRST ordering and the ready/valid handshake.
- Top level keeps the FSM, SIGNAL builder and counters.

Test Plan:
- RATE=1011, LEN=100 (0x064), bytes always valid -> SIGNAL = 1,0,1,1,0, 0,0,1,0,0,1,1,0,0,0,0,0, 0, 0×6; DATA = 16+800+6+42 = 864 bits; exactly 100 handshakes; one oDone.
- RATE=1101, LEN=1, byte 0xA5, MSB_FIRST=0 -> parity 0; PSDU bits 1,0,1,0,0,1,0,1; 18 pad bits; total DATA 48; oTail high for exactly 6 bits.
- RATE=0000 or LEN=0 -> oErr pulse, oBusy stays 0, no oValid.
- iByteValid dropped for 20 cycles mid-PSDU -> oValid gaps, oUnderrun=1, bit sequence unchanged; oUnderrun cleared by next iStart.
- iBitEn 1-in-4 with iStart reasserted mid-frame -> second iStart ignored; iRst=0 mid-PSDU -> all outputs 0 next cycle, no oDone.
- MSB_FIRST=1, RATE=0011, LEN=27 -> 16+216+6 = 238 -> pad 194 to 432; byte bits MSB first.
